mask_point_streamer: RTL and testbench

// Producer side of the point/tabulate interface consumed by the centroid unit. On start_in, scans a
// 1-bit-per-pixel mask frame buffer in raster order through a synchronous read port. Emits one

---
 rtl/vs_pkg.sv | 25 ++
 rtl/tag_delay_pipe.sv | 39 +++
 rtl/mask_point_streamer.sv | 158 +++++++++++++++
 tb/tb_mask_point_streamer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vs_pkg.sv
// Shared types and default geometry for the video mask/centroid path.
package vs_pkg;

  localparam int unsigned H_ACTIVE_DFLT   = 1280;
  localparam int unsigned V_ACTIVE_DFLT   = 720;
  localparam int unsigned RD_LATENCY_DFLT = 2;
  localparam int unsigned ADDR_W_DFLT     = 20;
  localparam int unsigned X_W             = 11;
  localparam int unsigned Y_W             = 10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

  localparam int unsigned POINT_W = $bits(point_t);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_TAB   = 2'd3
  } streamer_state_t;

endpackage

// File: rtl/tag_delay_pipe.sv
// Valid-tagged shift register; delays a payload to line up with a fixed-latency memory read.
module tag_delay_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_any_valid
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid     = r_valid[DEPTH-1];
  assign o_data      = r_data[DEPTH-1];
  // Used to detect that every issued read has come back.
  assign o_any_valid = |r_valid;

endmodule

// File: rtl/mask_point_streamer.sv
// Scans a 1bpp mask frame in raster order and streams the coordinates of set pixels,
// followed by a single end-of-frame tabulate pulse.
module mask_point_streamer
  import vs_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DFLT,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DFLT,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DFLT,
  parameter int unsigned ADDR_W     = ADDR_W_DFLT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_data_in,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic              valid_out,
  output logic              tabulate_out,
  output logic              busy_out,
  output logic [ADDR_W-1:0] point_count_out
);

  streamer_state_t   r_state;
  streamer_state_t   w_state_nxt;
  logic [X_W-1:0]    r_x;
  logic [X_W-1:0]    w_x_nxt;
  logic [Y_W-1:0]    r_y;
  logic [Y_W-1:0]    w_y_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_tab;
  logic              w_tab_nxt;
  logic              w_count_clr;
  logic              r_valid;
  logic [X_W-1:0]    r_x_out;
  logic [Y_W-1:0]    r_y_out;
  logic [ADDR_W-1:0] r_count;

  logic              w_last_px;
  logic              w_x_wrap;
  point_t            w_tag_in;
  point_t            w_tag_out;
  logic              w_tag_valid;
  logic              w_pipe_busy;
  logic              w_beat;

  assign w_x_wrap  = (r_x == X_W'(H_ACTIVE - 1));
  assign w_last_px = w_x_wrap && (r_y == Y_W'(V_ACTIVE - 1));
  assign w_tag_in  = {r_x, r_y};
  assign w_beat    = w_tag_valid & mem_data_in;

  // Tags travel alongside each read so returning bits know their coordinates.
  tag_delay_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (POINT_W)
  ) u_tag_pipe (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_valid     (r_state == S_SCAN),
    .i_data      (w_tag_in),
    .o_valid     (w_tag_valid),
    .o_data      (w_tag_out),
    .o_any_valid (w_pipe_busy)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_addr_nxt  = r_addr;
    w_busy_nxt  = r_busy;
    w_tab_nxt   = 1'b0;
    w_count_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        // busy stays up for one IDLE cycle after TAB, so start is refused there.
        w_busy_nxt = 1'b0;
        if (start_in && !r_busy) begin
          w_state_nxt = S_SCAN;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_addr_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_count_clr = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_last_px) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          if (w_x_wrap) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + Y_W'(1);
          end else begin
            w_x_nxt = r_x + X_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = S_TAB;
          w_tab_nxt   = 1'b1;
        end
      end
      S_TAB: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_tab   <= 1'b0;
      r_valid <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= w_busy_nxt;
      r_tab   <= w_tab_nxt;
      r_valid <= w_beat;
      if (w_beat) begin
        r_x_out <= w_tag_out.x;
        r_y_out <= w_tag_out.y;
      end
      if (w_count_clr) begin
        r_count <= '0;
      end else if (w_beat && (r_count != '1)) begin
        r_count <= r_count + ADDR_W'(1);
      end
    end
  end

  assign mem_addr_out    = r_addr;
  assign x_out           = r_x_out;
  assign y_out           = r_y_out;
  assign valid_out       = r_valid;
  assign tabulate_out    = r_tab;
  assign busy_out        = r_busy;
  assign point_count_out = r_count;

endmodule

// File: tb/tb_mask_point_streamer.sv
// Directed bench for mask_point_streamer on a 4x3 frame with a 2-cycle behavioural mask ROM.
module tb_mask_point_streamer;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int L    = 2;
  localparam int AW   = 20;
  localparam int NPIX = H * V;
  localparam int NCYC = NPIX + L + 3;

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b1;
  logic          start_in = 1'b0;
  logic [AW-1:0] mem_addr_out;
  logic          mem_data_in;
  logic [10:0]   x_out;
  logic [9:0]    y_out;
  logic          valid_out;
  logic          tabulate_out;
  logic          busy_out;
  logic [AW-1:0] point_count_out;

  mask_point_streamer #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .RD_LATENCY (L),
    .ADDR_W     (AW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .mem_addr_out    (mem_addr_out),
    .mem_data_in     (mem_data_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .valid_out       (valid_out),
    .tabulate_out    (tabulate_out),
    .busy_out        (busy_out),
    .point_count_out (point_count_out)
  );

  always #5 clk_in = ~clk_in;

  logic mask_mem [NPIX];
  logic rd_q1 = 1'b0;
  logic rd_q2 = 1'b0;

  always @(posedge clk_in) begin
    rd_q1 <= (int'(mem_addr_out) < NPIX) ? mask_mem[int'(mem_addr_out)] : 1'b0;
    rd_q2 <= rd_q1;
  end
  assign mem_data_in = rd_q2;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int exp_q[$];
  int sum_x;
  int sum_y;
  int n_pts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(mem_addr_out),    0);
    check({tag, "_x"},     32'(x_out),           0);
    check({tag, "_y"},     32'(y_out),           0);
    check({tag, "_valid"}, 32'(valid_out),       0);
    check({tag, "_tab"},   32'(tabulate_out),    0);
    check({tag, "_busy"},  32'(busy_out),        0);
    check({tag, "_count"}, 32'(point_count_out), 0);
  endtask

  // Pulses start, then follows the frame cycle by cycle; pokes[k] drives start_in in cycle k.
  task automatic scan(input logic [NPIX-1:0] m, input logic [31:0] pokes, input int rst_k);
    int tab_cnt  = 0;
    int tab_k    = -1;
    int busy_cnt = 0;
    int exp_n;
    int idx;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      mask_mem[i] = m[i];
      if (m[i]) exp_q.push_back(i);
    end
    exp_n = exp_q.size();
    sum_x = 0;
    sum_y = 0;
    n_pts = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk_in);
      start_in = pokes[k];
      check("addr", 32'(mem_addr_out), (k <= NPIX) ? 32'(k - 1) : 32'(NPIX - 1));
      if (busy_out) busy_cnt++;
      if (tabulate_out) begin
        tab_cnt++;
        tab_k = k;
        check("tab_without_beat", 32'(valid_out), 0);
      end
      if (valid_out) begin
        sum_x += int'(x_out);
        sum_y += int'(y_out);
        n_pts++;
        check("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          idx = exp_q.pop_front();
          check("beat_x",     32'(x_out), 32'(idx % H));
          check("beat_y",     32'(y_out), 32'(idx / H));
          check("beat_cycle", 32'(k),     32'(idx + L + 2));
        end
      end
      if (k == rst_k) return;
    end
    check("beats_left",  32'(exp_q.size()),    0);
    check("tab_count",   32'(tab_cnt),         1);
    check("tab_cycle",   32'(tab_k),           32'(NPIX + L + 2));
    check("busy_cycles", 32'(busy_cnt),        32'(NPIX + L + 3));
    check("point_count", 32'(point_count_out), 32'(exp_n));
    @(posedge clk_in);
    #1 start_in = 1'b0;
  endtask

  initial begin
    int tab_seen;
    for (int i = 0; i < NPIX; i++) mask_mem[i] = 1'b0;

    #1 check_all_zero("reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // empty mask
    scan(12'h000, 32'h0, -1);
    // single pixel (2,1)
    scan(12'h040, 32'h0, -1);
    // full mask
    scan(12'hFFF, 32'h0, -1);
    // last pixel only
    scan(12'h800, 32'h0, -1);
    // start re-pulsed mid-scan, in TAB, and in the cycle busy falls
    scan(12'hFFF, (32'h1 << 8) | (32'h1 << 16) | (32'h1 << 17), -1);
    scan(12'hFFF, 32'h0, -1);

    // reset after five beats of a full mask
    scan(12'hFFF, 32'h0, 8);
    check("pre_reset_beats", 32'(n_pts), 5);
    rst_in = 1'b1;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    tab_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (tabulate_out) tab_seen++;
    end
    check("no_tab_after_abort", 32'(tab_seen), 0);
    scan(12'hFFF, 32'h0, -1);

    // consumer centroid of (1,0),(3,2)
    scan(12'h802, 32'h0, -1);
    check("com_points", 32'(n_pts), 2);
    check("com_x", (n_pts != 0) ? 32'(sum_x / n_pts) : 32'hFFFF_FFFF, 2);
    check("com_y", (n_pts != 0) ? 32'(sum_y / n_pts) : 32'hFFFF_FFFF, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
